// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter driving the select of an 8-to-1 single-bit mux.
// The grant is bounded to MAX_HOLD cycles whenever another requester is waiting.
module mux8_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req_i,
    input  logic [7:0] d_i,
    output logic [7:0] gnt_o,
    output logic [2:0] s_o,
    output logic       valid_o,
    output logic       y_o
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    // First set bit of r at or after start, wrapping 7 -> 0.
    function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] start);
        logic [2:0] idx;
        logic       found;
        rr_pick = start;
        found   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = start + 3'(i);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end else begin
                found = found;
            end
        end
    endfunction

    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        onehot8 = 8'd1 << idx;
    endfunction

    state_e     state_q, state_d;
    logic [2:0] cur_q, cur_d;
    logic [2:0] ptr_q, ptr_d;
    logic [3:0] hold_q, hold_d;
    logic [7:0] gnt_q, gnt_d;
    logic       valid_q, valid_d;
    logic [7:0] others_s;
    logic       release_s;

    // Next-state selection for the grant FSM and its registered outputs.
    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        others_s  = req_i & ~onehot8(cur_q);
        release_s = !req_i[cur_q] || ((hold_q == HOLD_LAST) && (others_s != 8'd0));
        case (state_q)
            ST_IDLE: begin
                if (req_i != 8'd0) begin
                    state_d = ST_GRANT;
                    cur_d   = rr_pick(req_i, ptr_q);
                    ptr_d   = rr_pick(req_i, ptr_q) + 3'd1;
                    hold_d  = 4'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (release_s) begin
                    // Scan from cur+1 so an expired holder ranks last.
                    if (others_s != 8'd0) begin
                        cur_d  = rr_pick(others_s, cur_q + 3'd1);
                        ptr_d  = rr_pick(others_s, cur_q + 3'd1) + 3'd1;
                        hold_d = 4'd0;
                    end else begin
                        state_d = ST_IDLE;
                        ptr_d   = cur_q + 3'd1;
                        hold_d  = 4'd0;
                    end
                end else if (others_s == 8'd0) begin
                    hold_d = 4'd0;
                end else if (hold_q < HOLD_LAST) begin
                    hold_d = hold_q + 4'd1;
                end else begin
                    hold_d = hold_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cur_d   = 3'd0;
                ptr_d   = 3'd0;
                hold_d  = 4'd0;
            end
        endcase
        gnt_d   = (state_d == ST_GRANT) ? onehot8(cur_d) : 8'd0;
        valid_d = (state_d == ST_GRANT);
    end

    // State and output registers; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cur_q   <= 3'd0;
            ptr_q   <= 3'd0;
            hold_q  <= 4'd0;
            gnt_q   <= 8'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
        end
    end

    assign gnt_o   = gnt_q;
    assign s_o     = cur_q;
    assign valid_o = valid_q;
    assign y_o     = valid_q & d_i[cur_q];

endmodule
